backprop_weight_update: RTL and testbench

- Backward-pass engine for the output neuron of the 8-hidden/1-output network.
- Takes the network prediction and a training target, computes a saturated error, then updates the 8 output-layer weights one per cycle: w_k += (err * x_k) >>> LR_SHIFT.
- Owns the output-weight register file. Its flat weight bus replaces the hard-wired output-neuron weights at the top level.

---
 rtl/nn_pkg.sv | 60 ++++++
 rtl/weight_update_alu.sv | 38 +++
 rtl/backprop_weight_update.sv | 141 ++++++++++++++
 tb/tb_backprop_weight_update.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the output-neuron backward-pass engine.
//
// Contents:
//   - width constants for hidden activations, prediction/target, error and weights
//   - derived widths for the error difference, the error*activation product and
//     the weight sum before saturation
//   - bp_state_t : pass sequencer states
//   - sat_err    : clamp a (target - prediction) difference into the error range
//   - sat_w      : clamp an updated weight sum into the weight range
package nn_pkg;

  localparam int N_HIDDEN = 8;
  localparam int X_W      = 10;
  localparam int Y_W      = 23;
  localparam int ERR_W    = 12;
  localparam int W_W      = 8;
  localparam int LR_SHIFT = 4;

  localparam int IDX_W  = $clog2(N_HIDDEN);
  localparam int DIFF_W = Y_W + 1;
  localparam int PROD_W = ERR_W + X_W + 1;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic signed [DIFF_W-1:0] ERR_HI = DIFF_W'((2 ** (ERR_W - 1)) - 1);
  localparam logic signed [DIFF_W-1:0] ERR_LO = DIFF_W'(-(2 ** (ERR_W - 1)));
  localparam logic signed [SUM_W-1:0]  W_HI   = SUM_W'((2 ** (W_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0]  W_LO   = SUM_W'(-(2 ** (W_W - 1)));

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    UPDATE,
    DONE
  } bp_state_t;

  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [DIFF_W-1:0] v);
    logic signed [ERR_W-1:0] r;
    if (v > ERR_HI) begin
      r = ERR_HI[ERR_W-1:0];
    end else if (v < ERR_LO) begin
      r = ERR_LO[ERR_W-1:0];
    end else begin
      r = v[ERR_W-1:0];
    end
    return r;
  endfunction

  function automatic logic signed [W_W-1:0] sat_w(input logic signed [SUM_W-1:0] v);
    logic signed [W_W-1:0] r;
    if (v > W_HI) begin
      r = W_HI[W_W-1:0];
    end else if (v < W_LO) begin
      r = W_LO[W_W-1:0];
    end else begin
      r = v[W_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/weight_update_alu.sv
// Combinational single-weight update datapath.
//
// Computes new_w = sat_w(w + ((err * x) >>> LR_SHIFT)).
// The activation is unsigned and is zero-extended before the signed multiply,
// so the product sign follows the error alone.
//
// Ports:
//   w_i     in  W_W    current weight (signed)
//   x_i     in  X_W    hidden activation (unsigned)
//   err_i   in  ERR_W  saturated error (signed)
//   w_new_o out W_W    updated, saturated weight (signed)
module weight_update_alu
  import nn_pkg::*;
(
  input  logic signed [W_W-1:0]   w_i,
  input  logic        [X_W-1:0]   x_i,
  input  logic signed [ERR_W-1:0] err_i,
  output logic signed [W_W-1:0]   w_new_o
);

  logic signed [PROD_W-1:0] err_ext;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] delta;
  logic signed [SUM_W-1:0]  sum;

  // The full product always fits PROD_W bits, so a PROD_W x PROD_W multiply
  // keeping the low half is exact. The arithmetic shift rounds toward -inf.
  always_comb begin
    err_ext = PROD_W'(err_i);
    x_ext   = $signed({{(PROD_W - X_W){1'b0}}, x_i});
    prod    = err_ext * x_ext;
    delta   = prod >>> LR_SHIFT;
    sum     = SUM_W'(w_i) + SUM_W'(delta);
    w_new_o = sat_w(sum);
  end

endmodule

// File: rtl/backprop_weight_update.sv
// Backward-pass engine for the output neuron of the 8-hidden/1-output network.
//
// Captures a saturated error (target - prediction) and a snapshot of the hidden
// activations, then walks the 8 output weights one per cycle applying
// w_k += (err * x_k) >>> LR_SHIFT with saturation. It owns the output-weight
// register file and exposes it as a flat bus.
//
// Ports:
//   clk_i     in  1             clock
//   rst_i     in  1             asynchronous reset, active low
//   en_i      in  1             global enable; low freezes all state
//   start_i   in  1             request an update pass (IDLE only)
//   load_i    in  1             load init_w_i into the weights (IDLE only)
//   init_w_i  in  N_HIDDEN*W_W  initial weights, k at [k*W_W +: W_W]
//   x_flat_i  in  N_HIDDEN*X_W  hidden activations, k at [k*X_W +: X_W]
//   y_i       in  Y_W           network prediction
//   target_i  in  Y_W           training target
//   w_flat_o  out N_HIDDEN*W_W  current weights, same packing as init_w_i
//   err_o     out ERR_W         last captured saturated error
//   busy_o    out 1             high in CAPTURE and UPDATE
//   done_o    out 1             one-cycle pulse at pass completion
module backprop_weight_update
  import nn_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      start_i,
  input  logic                      load_i,
  input  logic [N_HIDDEN*W_W-1:0]   init_w_i,
  input  logic [N_HIDDEN*X_W-1:0]   x_flat_i,
  input  logic [Y_W-1:0]            y_i,
  input  logic [Y_W-1:0]            target_i,
  output logic [N_HIDDEN*W_W-1:0]   w_flat_o,
  output logic [ERR_W-1:0]          err_o,
  output logic                      busy_o,
  output logic                      done_o
);

  bp_state_t                state_q, state_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic signed [ERR_W-1:0]  err_q, err_d;
  logic [N_HIDDEN*X_W-1:0]  x_snap_q, x_snap_d;
  logic signed [W_W-1:0]    w_q [N_HIDDEN];
  logic signed [W_W-1:0]    w_d [N_HIDDEN];

  logic signed [DIFF_W-1:0] diff;
  logic [X_W-1:0]           alu_x;
  logic signed [W_W-1:0]    alu_w;
  logic signed [W_W-1:0]    alu_w_new;

  // One shared ALU; the weight index selects its operands from the snapshot
  // and the register file.
  assign alu_x = x_snap_q[int'(index_q) * X_W +: X_W];
  assign alu_w = w_q[index_q];

  weight_update_alu u_alu (
    .w_i     (alu_w),
    .x_i     (alu_x),
    .err_i   (err_q),
    .w_new_o (alu_w_new)
  );

  // State, index, error, snapshot and weights. Weights reset to 1..N so a
  // freshly reset network starts from its nominal initial weights.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      index_q  <= '0;
      err_q    <= '0;
      x_snap_q <= '0;
      for (int k = 0; k < N_HIDDEN; k++) begin
        w_q[k] <= W_W'(k + 1);
      end
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      err_q    <= err_d;
      x_snap_q <= x_snap_d;
      for (int k = 0; k < N_HIDDEN; k++) begin
        w_q[k] <= w_d[k];
      end
    end
  end

  // Next-state and outputs. Every update is gated by en_i so a stall simply
  // holds the machine; done is suppressed while stalled so a frozen DONE state
  // cannot stretch the pulse.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    err_d    = err_q;
    x_snap_d = x_snap_q;
    w_d      = w_q;
    busy_o   = (state_q == CAPTURE) || (state_q == UPDATE);
    done_o   = en_i && (state_q == DONE);

    diff = $signed({1'b0, target_i}) - $signed({1'b0, y_i});

    if (en_i) begin
      case (state_q)
        IDLE: begin
          // Load takes priority; a simultaneous start is dropped.
          if (load_i) begin
            for (int k = 0; k < N_HIDDEN; k++) begin
              w_d[k] = init_w_i[k*W_W +: W_W];
            end
          end else if (start_i) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          x_snap_d = x_flat_i;
          err_d    = sat_err(diff);
          index_d  = '0;
          state_d  = UPDATE;
        end
        UPDATE: begin
          w_d[index_q] = alu_w_new;
          index_d      = index_q + 1'b1;
          if (index_q == IDX_W'(N_HIDDEN - 1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign err_o = err_q;

  for (genvar g = 0; g < N_HIDDEN; g++) begin : g_wout
    assign w_flat_o[g*W_W +: W_W] = w_q[g];
  end

endmodule

// File: tb/tb_backprop_weight_update.sv
// Self-checking bench for backprop_weight_update.
//
// A behavioural model tracks the pass position, the captured error and the
// weight values using plain integer arithmetic; a compare process checks every
// DUT output against it on each falling edge. Directed scenarios pin the model
// with hand-computed literals, then randomized passes exercise the rest.
module tb_backprop_weight_update;
  import nn_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        start;
  logic        load;
  logic [63:0] init_w;
  logic [79:0] x_flat;
  logic [22:0] y;
  logic [22:0] target;
  logic [63:0] w_flat_o;
  logic [11:0] err_o;
  logic        busy_o;
  logic        done_o;

  int n_checks;
  int n_pass;

  // Model state: m_pos is -1 when idle, 0 for the capture cycle, 1..8 while
  // weight m_pos-1 is being written, 9 for the completion cycle.
  int m_pos;
  int m_err;
  int m_w   [8];
  int m_new [8];

  logic [63:0] exp_w;
  logic [11:0] exp_err;

  backprop_weight_update dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .en_i     (en),
    .start_i  (start),
    .load_i   (load),
    .init_w_i (init_w),
    .x_flat_i (x_flat),
    .y_i      (y),
    .target_i (target),
    .w_flat_o (w_flat_o),
    .err_o    (err_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampI(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Floor division by a positive divisor (learning-rate scaling).
  function automatic int floorDiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [79:0] xAll(input int v);
    logic [79:0] r;
    for (int k = 0; k < 8; k++) r[k*10 +: 10] = 10'(v);
    return r;
  endfunction

  function automatic logic [63:0] wAll(input int v);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = 8'(v);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: whole-pass arithmetic computed at capture, committed
  // one weight per enabled cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = -1;
      m_err = 0;
      for (int k = 0; k < 8; k++) m_w[k] = k + 1;
    end else if (en) begin
      if (m_pos < 0) begin
        if (load) begin
          for (int k = 0; k < 8; k++) m_w[k] = int'($signed(init_w[k*8 +: 8]));
        end else if (start) begin
          m_pos = 0;
        end
      end else if (m_pos == 0) begin
        m_err = clampI(int'(target) - int'(y), -2048, 2047);
        for (int k = 0; k < 8; k++) begin
          m_new[k] = clampI(m_w[k] + floorDiv(m_err * int'(x_flat[k*10 +: 10]), 16), -128, 127);
        end
        m_pos = 1;
      end else if (m_pos <= 8) begin
        m_w[m_pos - 1] = m_new[m_pos - 1];
        m_pos = m_pos + 1;
      end else begin
        m_pos = -1;
      end
    end
  end

  // Compare process: every output, every falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 8; k++) exp_w[k*8 +: 8] = m_w[k][7:0];
    exp_err = m_err[11:0];
    checkOutput("w_flat", w_flat_o, exp_w);
    checkOutput("err", 64'(err_o), 64'(exp_err));
    checkOutput("busy", 64'(busy_o), 64'((m_pos >= 0) && (m_pos <= 8)));
    checkOutput("done", 64'(done_o), 64'((m_pos == 9) && en));
  end

  task automatic applyStimulus(input bit ld, input bit st, input logic [63:0] iw,
                               input logic [79:0] xf, input logic [22:0] yy,
                               input logic [22:0] tt);
    @(posedge clk);
    #2;
    load   = ld;
    start  = st;
    init_w = iw;
    x_flat = xf;
    y      = yy;
    target = tt;
  endtask

  task automatic loadWeights(input logic [63:0] iw);
    applyStimulus(1'b1, 1'b0, iw, x_flat, y, target);
    applyStimulus(1'b0, 1'b0, iw, x_flat, y, target);
  endtask

  // Runs one pass; optionally stalls en for stall_len cycles after edge
  // stall_at and scrambles inputs (including start/load) after capture.
  task automatic runPass(input logic [79:0] xf, input logic [22:0] yy, input logic [22:0] tt,
                         input int stall_at, input int stall_len, input bit scramble);
    int edges;
    bit seen;
    applyStimulus(1'b0, 1'b1, init_w, xf, yy, tt);
    @(posedge clk);
    #2;
    start = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      if (stall_len > 0 && edges == stall_at) en = 1'b0;
      if (stall_len > 0 && edges == stall_at + stall_len) en = 1'b1;
      if (scramble && edges >= 1) begin
        for (int k = 0; k < 8; k++) x_flat[k*10 +: 10] = 10'($urandom_range(0, 1023));
        y      = 23'($urandom);
        target = 23'($urandom);
        start  = 1'($urandom_range(0, 1));
        load   = 1'($urandom_range(0, 1));
        init_w = {$urandom, $urandom};
      end
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #2;
        edges++;
      end
    end
    start = 1'b0;
    load  = 1'b0;
    en    = 1'b1;
    if (!seen) checkOutput("done_timeout", 64'(0), 64'(1));
    else       checkOutput("done_latency", 64'(edges), 64'(9 + stall_len));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [22:0] ry;
    logic [22:0] rt;
    logic [79:0] rx;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    start    = 1'b0;
    load     = 1'b0;
    init_w   = '0;
    x_flat   = '0;
    y        = '0;
    target   = '0;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset values");
    checkOutput("reset_w", w_flat_o, 64'h0807060504030201);
    checkOutput("reset_busy", 64'(busy_o), 64'(0));
    checkOutput("reset_err", 64'(err_o), 64'(0));

    $display("[TB] basic pass");
    runPass(xAll(10), 23'd100, 23'd132, 0, 0, 1'b0);
    checkOutput("basic_w", w_flat_o, 64'h1C1B1A1918171615);
    checkOutput("basic_err", 64'(err_o), 64'h020);

    $display("[TB] negative saturation");
    loadWeights(64'h0);
    runPass(xAll(1023), 23'd2048, 23'd0, 0, 0, 1'b0);
    checkOutput("negsat_w", w_flat_o, 64'h8080808080808080);
    checkOutput("negsat_err", 64'(err_o), 64'h800);

    $display("[TB] rounding toward minus infinity");
    loadWeights(wAll(5));
    runPass(xAll(1), 23'd500, 23'd499, 0, 0, 1'b0);
    checkOutput("round_neg_w", w_flat_o, wAll(4));
    runPass(xAll(1), 23'd500, 23'd501, 0, 0, 1'b0);
    checkOutput("round_pos_w", w_flat_o, wAll(4));

    $display("[TB] error saturation and zero error");
    runPass(xAll(0), 23'd0, 23'h7FFFFF, 0, 0, 1'b0);
    checkOutput("possat_err", 64'(err_o), 64'h7FF);
    runPass(xAll(1023), 23'd777, 23'd777, 0, 0, 1'b1);
    checkOutput("zero_err_w", w_flat_o, wAll(4));

    $display("[TB] load with start");
    applyStimulus(1'b1, 1'b1, 64'h1122334455667788, x_flat, y, target);
    applyStimulus(1'b0, 1'b0, init_w, x_flat, y, target);
    @(negedge clk);
    checkOutput("loadstart_busy", 64'(busy_o), 64'(0));
    checkOutput("loadstart_w", w_flat_o, 64'h1122334455667788);

    $display("[TB] enable stall");
    loadWeights(64'h0);
    runPass(xAll(10), 23'd100, 23'd132, 4, 3, 1'b0);
    checkOutput("stall_w", w_flat_o, wAll(20));

    $display("[TB] reset mid-pass");
    applyStimulus(1'b0, 1'b1, init_w, xAll(500), 23'd0, 23'd1000);
    @(posedge clk);
    #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_w", w_flat_o, 64'h0807060504030201);
    checkOutput("midreset_busy", 64'(busy_o), 64'(0));
    checkOutput("midreset_done", 64'(done_o), 64'(0));
    checkOutput("midreset_err", 64'(err_o), 64'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] randomized passes");
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 2) == 0) loadWeights({$urandom, $urandom});
      for (int k = 0; k < 8; k++) rx[k*10 +: 10] = 10'($urandom_range(0, 1023));
      ry = 23'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        rt = 23'($urandom);
      end else begin
        rt = 23'(clampI(int'(ry) + int'($urandom_range(0, 400)) - 200, 0, 8388607));
      end
      if ($urandom_range(0, 1) == 0) runPass(rx, ry, rt, 0, 0, 1'($urandom_range(0, 1)));
      else runPass(rx, ry, rt, $urandom_range(2, 6), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
